tlc_safety_monitor: RTL and testbench

//  Downstream stage of the traffic-light FSM. Takes the raw road A/B light codes (rA, rB) and drives the lamp outputs.

---
 rtl/tlc_safety_monitor.sv | 134 +++++++++++++
 tb/tb_tlc_safety_monitor.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/tlc_safety_monitor.sv
// Safety stage between the traffic-light FSM and the lamp drivers. It passes
// legal light codes through one cycle late and latches a fault, with both roads RED, on any violation.
//
// state  | meaning
// INIT   | forced all-RED for STARTUP_CYC cycles, no checks
// PASS   | legal codes forwarded to the lamps with one cycle of latency
// FAULT  | all-RED, fault_code held until cleared with both roads RED
module tlc_safety_monitor #(
  parameter int STARTUP_CYC = 4,
  parameter int MIN_YEL     = 2,
  parameter int MAX_GRN     = 16,
  parameter int CW          = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rA,
  input  logic [1:0] rB,
  input  logic       fault_clr,
  output logic [1:0] oA,
  output logic [1:0] oB,
  output logic       pass,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;
  localparam logic [1:0] ILL = 2'b11;

  localparam logic [CW-1:0] G_SAT  = CW'(MAX_GRN + 1);
  localparam logic [CW-1:0] G_LIM  = CW'(MAX_GRN);
  localparam logic [CW-1:0] Y_MIN  = CW'(MIN_YEL);
  localparam logic [CW-1:0] Y_SAT  = '1;
  localparam logic [CW-1:0] S_LAST = CW'(STARTUP_CYC - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {S_INIT, S_PASS, S_FAULT} state_t;

  state_t        state;
  logic [1:0]    prev_a, prev_b;
  logic [CW-1:0] ycnt_a, ycnt_b, gcnt_a, gcnt_b, scnt;
  logic [2:0]    code;

  function automatic logic bad_seq(input logic [1:0] prev, input logic [1:0] cur);
    return (prev == RED && cur == YEL) || (prev == GRN && cur == RED) ||
           (prev == YEL && cur == GRN);
  endfunction

  // History runs in every state so the first PASS cycle already sees valid predecessors.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_a <= RED;
      prev_b <= RED;
      ycnt_a <= '0;
      ycnt_b <= '0;
      gcnt_a <= '0;
      gcnt_b <= '0;
    end else begin
      prev_a <= rA;
      prev_b <= rB;
      ycnt_a <= (rA == YEL) ? ((ycnt_a == Y_SAT) ? ycnt_a : ycnt_a + ONE) : '0;
      ycnt_b <= (rB == YEL) ? ((ycnt_b == Y_SAT) ? ycnt_b : ycnt_b + ONE) : '0;
      gcnt_a <= (rA == GRN) ? ((gcnt_a == G_SAT) ? gcnt_a : gcnt_a + ONE) : '0;
      gcnt_b <= (rB == GRN) ? ((gcnt_b == G_SAT) ? gcnt_b : gcnt_b + ONE) : '0;
    end
  end

  always_comb begin
    code = 3'd0;
    if (rA != RED && rB != RED)
      code = 3'd1;
    else if (rA == ILL || rB == ILL)
      code = 3'd2;
    else if (bad_seq(prev_a, rA) || bad_seq(prev_b, rB))
      code = 3'd3;
    else if ((prev_a == YEL && rA == RED && ycnt_a < Y_MIN) ||
             (prev_b == YEL && rB == RED && ycnt_b < Y_MIN))
      code = 3'd4;
    else if ((rA == GRN && gcnt_a >= G_LIM) || (rB == GRN && gcnt_b >= G_LIM))
      code = 3'd5;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      oA         <= RED;
      oB         <= RED;
      pass       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 3'd0;
      scnt       <= '0;
    end else begin
      case (state)
        S_INIT: begin
          oA <= RED;
          oB <= RED;
          if (scnt == S_LAST) begin
            state <= S_PASS;
            pass  <= 1'b1;
            scnt  <= '0;
          end else begin
            scnt <= scnt + ONE;
          end
        end
        S_PASS: begin
          if (code != 3'd0) begin
            state      <= S_FAULT;
            oA         <= RED;
            oB         <= RED;
            pass       <= 1'b0;
            fault      <= 1'b1;
            fault_code <= code;
          end else begin
            oA <= rA;
            oB <= rB;
          end
        end
        S_FAULT: begin
          oA <= RED;
          oB <= RED;
          if (fault_clr && rA == RED && rB == RED) begin
            state      <= S_INIT;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            scnt       <= '0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_tlc_safety_monitor.sv
// Directed bench for tlc_safety_monitor: a vector table for reset, pass-through,
// faults and clearing, plus a hand-written green-timeout sequence.
module tb_tlc_safety_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rA, rB;
  logic       fault_clr;
  logic [1:0] oA, oB;
  logic       pass, fault;
  logic [2:0] fault_code;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tlc_safety_monitor dut (
    .clk(clk), .rst(rst), .rA(rA), .rB(rB), .fault_clr(fault_clr),
    .oA(oA), .oB(oB), .pass(pass), .fault(fault), .fault_code(fault_code)
  );

  typedef struct {
    logic       rst;
    logic [1:0] a, b;
    logic       clr;
    logic [1:0] ea, eb;
    logic       ep, ef;
    logic [2:0] ec;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, input logic [1:0] a, input logic [1:0] b, input logic c,
                   input logic [1:0] ea, input logic [1:0] eb, input logic ep,
                   input logic ef, input logic [2:0] ec);
    vec_t t;
    t.rst = r; t.a = a; t.b = b; t.clr = c;
    t.ea = ea; t.eb = eb; t.ep = ep; t.ef = ef; t.ec = ec;
    vecs.push_back(t);
  endtask

  // Startup: rst=0, both RED, three cycles pass=0 then PASS.
  task automatic v_init(input logic [1:0] a);
    for (int i = 0; i < 3; i++) v(0, a, 0, 0, 0, 0, 0, 0, 0);
    v(0, a, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic chk(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    else
      n_pass++;
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] b);
    rst = 1'b0; rA = a; rB = b; fault_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rA = 2'b00; rB = 2'b00; fault_clr = 1'b0;

    // reset, startup window
    v(1, 0, 0, 0, 0, 0, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 0, 0, 0);
    v_init(0);
    // normal road A cycle, minimum yellow exactly met
    for (int i = 0; i < 5; i++) v(0, 2, 0, 0, 2, 0, 1, 0, 0);
    v(0, 1, 0, 0, 1, 0, 1, 0, 0);
    v(0, 1, 0, 0, 1, 0, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // fault_clr has no effect in PASS
    v(0, 0, 0, 1, 0, 0, 1, 0, 0);
    // road B cycle
    v(0, 0, 2, 0, 0, 2, 1, 0, 0);
    v(0, 0, 1, 0, 0, 1, 1, 0, 0);
    v(0, 0, 1, 0, 0, 1, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // conflict, held, clear ignored while A not RED, then accepted
    v(0, 2, 2, 0, 0, 0, 0, 1, 1);
    v(0, 0, 0, 0, 0, 0, 0, 1, 1);
    v(0, 2, 0, 1, 0, 0, 0, 1, 1);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0);
    v_init(0);
    // illegal code
    v(0, 3, 0, 0, 0, 0, 0, 1, 2);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0);
    v_init(0);
    // conflict and illegal together: lowest code wins
    v(0, 3, 2, 0, 0, 0, 0, 1, 1);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0);
    v_init(0);
    // GRN -> RED
    v(0, 2, 0, 0, 2, 0, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 3);
    // reset mid-FAULT, GREEN during INIT, RED at first PASS cycle
    v(1, 0, 0, 0, 0, 0, 0, 0, 0);
    v_init(2);
    v(0, 0, 0, 0, 0, 0, 0, 1, 3);
    // reset mid-FAULT, then reset mid-INIT restarts the startup window
    v(1, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 0, 0, 0);
    v_init(0);
    // short yellow
    v(0, 2, 0, 0, 2, 0, 1, 0, 0);
    v(0, 1, 0, 0, 1, 0, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 4);
    // fresh start for the timeout sequence
    v(1, 0, 0, 0, 0, 0, 0, 0, 0);
    v_init(0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; rA = vecs[i].a; rB = vecs[i].b; fault_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      chk("oA", i, {1'b0, oA}, {1'b0, vecs[i].ea});
      chk("oB", i, {1'b0, oB}, {1'b0, vecs[i].eb});
      chk("pass", i, {2'b00, pass}, {2'b00, vecs[i].ep});
      chk("fault", i, {2'b00, fault}, {2'b00, vecs[i].ef});
      chk("fault_code", i, fault_code, vecs[i].ec);
    end

    // green timeout: 16 GREEN samples pass, the 17th faults
    for (int i = 1; i <= 17; i++) begin
      step(2'b10, 2'b00);
      if (i < 17) begin
        chk("tmo_oA", i, {1'b0, oA}, 3'd2);
        chk("tmo_fault", i, {2'b00, fault}, 3'd0);
      end else begin
        chk("tmo_oA", i, {1'b0, oA}, 3'd0);
        chk("tmo_fault", i, {2'b00, fault}, 3'd1);
        chk("tmo_code", i, fault_code, 3'd5);
      end
    end
    for (int i = 18; i <= 19; i++) begin
      step(2'b10, 2'b00);
      chk("tmo_hold_oA", i, {1'b0, oA}, 3'd0);
      chk("tmo_hold_code", i, fault_code, 3'd5);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
